// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, function codes,
// FSM states, datapath select codes and the instruction-class bundle.
package multi_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Exactly one of cal_r..other is set; is_jal/is_jr refine the jump class.
    typedef struct packed {
        logic cal_r;
        logic cal_i;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic other;
        logic is_jal;
        logic is_jr;
    } instr_class_t;

    function automatic logic [2:0] alu_op(input logic [5:0] op, input logic [5:0] func);
        logic [2:0] code;
        code = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_SUBU: code = ALU_SUB;
                    FN_OR:   code = ALU_OR;
                    FN_XOR:  code = ALU_XOR;
                    default: code = ALU_ADD;
                endcase
            end
            OP_BEQ:  code = ALU_SUB;
            OP_ORI:  code = ALU_OR;
            OP_LUI:  code = ALU_LUI;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/function fields onto
// one-hot instruction classes; anything unrecognised lands in 'other'.
module mc_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output instr_class_t cls
);

    logic rtype;

    assign rtype = (op == OP_RTYPE);

    always_comb begin
        cls        = '0;
        cls.cal_r  = rtype && (func == FN_ADDU || func == FN_SUBU ||
                               func == FN_OR   || func == FN_XOR);
        cls.cal_i  = (op == OP_ORI) || (op == OP_LUI);
        cls.load   = (op == OP_LW);
        cls.store  = (op == OP_SW);
        cls.branch = (op == OP_BEQ);
        cls.is_jal = (op == OP_JAL);
        cls.is_jr  = rtype && (func == FN_JR);
        cls.jump   = (op == OP_J) || cls.is_jal || cls.is_jr;
        cls.other  = !(cls.cal_r || cls.cal_i || cls.load || cls.store ||
                       cls.branch || cls.jump);
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB) with a retired
// instruction counter; datapath controls are decoded from state and IR fields.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        zero,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  WDSel,
    output logic        ALUsrc,
    output logic        sign,
    output logic [1:0]  NPCSel,
    output logic [2:0]  ALUControl,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    state_t       state_q;
    state_t       state_d;
    logic [31:0]  cnt_q;
    instr_class_t cls;

    mc_decode u_decode (
        .op   (op),
        .func (func),
        .cls  (cls)
    );

    assign state     = state_q;
    assign instr_cnt = cnt_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = (cls.jump || cls.other) ? FETCH : EXE;
            EXE: begin
                if (cls.branch)
                    state_d = FETCH;
                else if (cls.load || cls.store)
                    state_d = MEM;
                else
                    state_d = WB;
            end
            MEM:     state_d = cls.store ? FETCH : WB;
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // An instruction retires whenever the FSM returns to FETCH from elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != FETCH && state_d == FETCH)
                cnt_q <= cnt_q + 32'd1;
        end
    end

    // Reset forces every output to its idle FETCH value with all enables off.
    always_comb begin
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = RD_RT;
        WDSel      = WD_ALU;
        ALUsrc     = 1'b0;
        sign       = 1'b0;
        NPCSel     = NPC_PC4;
        ALUControl = ALU_ADD;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    IRWr = 1'b1;
                    PCWr = 1'b1;
                end
                DECODE: begin
                    if (cls.jump) begin
                        PCWr   = 1'b1;
                        NPCSel = cls.is_jr ? NPC_JR : NPC_JUMP;
                    end
                    if (cls.is_jal) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RA;
                        WDSel    = WD_PC;
                    end
                end
                EXE, MEM, WB: begin
                    ALUControl = alu_op(op, func);
                    ALUsrc     = cls.cal_i || cls.load || cls.store;
                    sign       = cls.load || cls.store || cls.branch;
                    if (state_q == EXE && cls.branch) begin
                        PCWr   = zero;
                        NPCSel = NPC_BRANCH;
                    end
                    if (state_q == MEM)
                        MemWrite = cls.store;
                    if (state_q == WB) begin
                        RegWrite = 1'b1;
                        RegDst   = cls.cal_r ? RD_RD : RD_RT;
                        WDSel    = cls.load ? WD_DM : WD_ALU;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed and random instruction
// streams compared cycle by cycle against a per-mnemonic behavioural model.
module tb_multi_cycle_ctrl;

    localparam int M_ADDU = 0,  M_SUBU = 1, M_OR  = 2,  M_XOR = 3;
    localparam int M_ORI  = 4,  M_LUI  = 5, M_LW  = 6,  M_SW  = 7;
    localparam int M_BEQ  = 8,  M_J    = 9, M_JAL = 10, M_JR  = 11;
    localparam int M_NOP  = 12, M_UNDEF = 13;

    int         cyc_tab  [14] = '{4, 4, 4, 4, 4, 4, 5, 4, 3, 2, 2, 2, 2, 2};
    logic [2:0] alu_tab  [14] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd3, 3'd4, 3'd0,
                                  3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic       src_tab  [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic       sign_tab [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        PCWr, IRWr, RegWrite, MemWrite, ALUsrc, sign;
    logic [1:0]  RegDst, WDSel, NPCSel;
    logic [2:0]  ALUControl, state;
    logic [31:0] instr_cnt;
    logic [17:0] obs;

    int checks = 0;
    int passed = 0;
    int exp_cnt = 0;

    multi_cycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .func       (func),
        .zero       (zero),
        .PCWr       (PCWr),
        .IRWr       (IRWr),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .RegDst     (RegDst),
        .WDSel      (WDSel),
        .ALUsrc     (ALUsrc),
        .sign       (sign),
        .NPCSel     (NPCSel),
        .ALUControl (ALUControl),
        .state      (state),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {PCWr, IRWr, RegWrite, MemWrite, RegDst, WDSel,
                  ALUsrc, sign, NPCSel, ALUControl, state};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    // Expected outputs for cycle k of a mnemonic: phases run F,D,E,(M),(W).
    function automatic logic [17:0] model(input int m, input int k, input logic z);
        logic       pcwr, irwr, rw, mw, asrc, sgn;
        logic [1:0] rd, wd, npc;
        logic [2:0] alu, st;
        int         ph;
        pcwr = 0; irwr = 0; rw = 0; mw = 0; asrc = 0; sgn = 0;
        rd = 0; wd = 0; npc = 0; alu = 0;
        ph = (k == 3 && m != M_LW && m != M_SW) ? 4 : k;
        st = 3'(ph);
        if (ph == 0) begin
            irwr = 1; pcwr = 1;
        end else if (ph == 1) begin
            if (m == M_J || m == M_JAL || m == M_JR) begin
                pcwr = 1;
                npc  = (m == M_JR) ? 2'd3 : 2'd2;
            end
            if (m == M_JAL) begin
                rw = 1; rd = 2'd2; wd = 2'd2;
            end
        end else begin
            alu  = alu_tab[m];
            asrc = src_tab[m];
            sgn  = sign_tab[m];
            if (ph == 2 && m == M_BEQ) begin
                pcwr = z; npc = 2'd1;
            end
            if (ph == 3 && m == M_SW) mw = 1;
            if (ph == 4) begin
                rw = 1;
                rd = (m <= M_XOR) ? 2'd1 : 2'd0;
                wd = (m == M_LW) ? 2'd1 : 2'd0;
            end
        end
        return {pcwr, irwr, rw, mw, rd, wd, asrc, sgn, npc, alu, st};
    endfunction

    function automatic bit known_op(input logic [5:0] o);
        return o == 6'h00 || o == 6'h0D || o == 6'h0F || o == 6'h23 ||
               o == 6'h2B || o == 6'h04 || o == 6'h02 || o == 6'h03;
    endfunction

    task automatic encode(input int m);
        logic [5:0] rnd;
        rnd = 6'($urandom_range(0, 63));
        case (m)
            M_ADDU:  begin op = 6'h00; func = 6'h21; end
            M_SUBU:  begin op = 6'h00; func = 6'h23; end
            M_OR:    begin op = 6'h00; func = 6'h25; end
            M_XOR:   begin op = 6'h00; func = 6'h26; end
            M_ORI:   begin op = 6'h0D; func = rnd; end
            M_LUI:   begin op = 6'h0F; func = rnd; end
            M_LW:    begin op = 6'h23; func = rnd; end
            M_SW:    begin op = 6'h2B; func = rnd; end
            M_BEQ:   begin op = 6'h04; func = rnd; end
            M_J:     begin op = 6'h02; func = rnd; end
            M_JAL:   begin op = 6'h03; func = rnd; end
            M_JR:    begin op = 6'h00; func = 6'h08; end
            M_NOP:   begin op = 6'h00; func = 6'h00; end
            default: begin
                op = 6'h3F;
                if ($urandom_range(0, 1) == 1) begin
                    op = 6'($urandom_range(0, 63));
                    while (known_op(op)) op = 6'($urandom_range(0, 63));
                end
                func = rnd;
            end
        endcase
    endtask

    // Entered just after a falling edge with the DUT in FETCH; leaves it the same way.
    task automatic applyStimulus(input int m, input logic z);
        encode(m);
        zero = z;
        #1;
        for (int k = 0; k < cyc_tab[m]; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            checkOutput($sformatf("m%0d_op%0h_c%0d", m, op, k), 32'(obs), 32'(model(m, k, z)));
        end
        @(negedge clk);
        #1;
        exp_cnt++;
        checkOutput($sformatf("m%0d_retire_state", m), 32'(state), 32'd0);
        checkOutput($sformatf("m%0d_instr_cnt", m), instr_cnt, 32'(exp_cnt));
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'h00;
        func  = 6'h00;
        zero  = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_enables", {28'd0, PCWr, IRWr, RegWrite, MemWrite}, 32'd0);
        checkOutput("rst_selects", {18'd0, RegDst, WDSel, ALUsrc, sign, NPCSel, ALUControl, 3'd0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_cnt", instr_cnt, 32'd0);

        applyStimulus(M_ADDU, 1'b0);
        applyStimulus(M_LW, 1'b0);
        applyStimulus(M_SW, 1'b0);
        applyStimulus(M_BEQ, 1'b1);
        applyStimulus(M_BEQ, 1'b0);
        applyStimulus(M_JAL, 1'b0);
        applyStimulus(M_UNDEF, 1'b0);
        applyStimulus(M_NOP, 1'b0);

        for (int i = 0; i < 200; i++)
            applyStimulus(int'($urandom_range(0, 13)), 1'($urandom_range(0, 1)));

        // Reset arriving during the MEM cycle of a store must kill the write.
        encode(M_SW);
        zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("sw_mem_before_rst", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("sw_mem_rst_memwrite", 32'(MemWrite), 32'd0);
        checkOutput("sw_mem_rst_enables", {29'd0, PCWr, IRWr, RegWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        checkOutput("sw_mem_rst_state", 32'(state), 32'd0);
        checkOutput("sw_mem_rst_cnt", instr_cnt, 32'd0);
        applyStimulus(M_ORI, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction[31:26] from the external IR; valid from DECODE onward.
REQ-005 func  in  6  instruction[5:0] from the external IR.
REQ-006 zero  in  1  ALU equality flag (rs==rt); sampled in EXE for beq.
REQ-007 PCWr  out  1  PC register write enable.
REQ-008 IRWr  out  1  IR write enable.
REQ-009 RegWrite  out  1  GRF write enable.
REQ-010 MemWrite  out  1  DM write enable.
REQ-011 RegDst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
REQ-012 WDSel  out  2  GRF write-data select: 00 ALU result, 01 DM data, 10 PC register.
REQ-013 ALUsrc  out  1  ALU operand B select: 0 rt, 1 extended imm.
REQ-014 sign  out  1  immediate extension: 1 sign-extend, 0 zero-extend.
REQ-015 NPCSel  out  2  next-PC select: 00 PC+4, 01 branch target, 10 j/jal target, 11 rs (jr).
REQ-016 ALUControl  out  3  ALU operation code: 000 add, 001 sub, 011 or, 100 lui, 101 xor.
REQ-017 state  out  3  current FSM state, for debug.
REQ-018 instr_cnt  out  32  count of retired instructions.

Function
REQ-019 The FSM SHALL use five states: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
REQ-020 Instruction classes SHALL be:
- Cal_R: addu, subu, or, xor.
- Cal_I: ori, lui.
- Load: lw. Store: sw. Branch: beq.
- Jump: j, jal, jr.
- Other: nop and any undecoded encoding, treated as nop.
REQ-021 FETCH SHALL assert IRWr=1, PCWr=1, NPCSel=00, then go to DECODE unconditionally.
REQ-022 DECODE with Jump SHALL assert PCWr=1 with NPCSel 10 (j/jal) or 11 (jr), then go to FETCH.
REQ-023 DECODE with jal SHALL also assert RegWrite=1, RegDst=10, WDSel=10 (PC already holds instruction address + 4).
REQ-024 DECODE with Other SHALL go to FETCH with all enables 0; any other class SHALL go to EXE.
REQ-025 EXE with beq SHALL assert ALUControl=001, sign=1, PCWr=zero, NPCSel=01, then go to FETCH.
REQ-026 EXE with Cal_R or Cal_I SHALL go to WB.
REQ-027 EXE with Load or Store SHALL go to MEM with ALUsrc=1, sign=1, ALUControl=000.
REQ-028 MEM with sw SHALL assert MemWrite=1 and go to FETCH; MEM with lw SHALL go to WB.
REQ-029 WB SHALL assert RegWrite=1, then go to FETCH, with:
- RegDst=01, WDSel=00 for Cal_R;
- RegDst=00, WDSel=00, ALUsrc=1 for Cal_I;
- RegDst=00, WDSel=01 for lw.
REQ-030 ALUControl and ALUsrc SHALL be held stable across EXE, MEM and WB of one instruction.
- addu/lw/sw: 000; subu/beq: 001; or/ori: 011; lui: 100; xor: 101; otherwise 000.
- sign=1 only for lw/sw/beq.
REQ-031 All outputs SHALL be combinational functions of state, op, func and zero; unlisted outputs SHALL be 0.
REQ-032 Cycles per instruction SHALL be:
- Cal_R, Cal_I, sw: 4; lw: 5; beq: 3; Jump: 2; Other: 2.
REQ-033 instr_cnt SHALL increment by 1, modulo 2^32 (wrap to 0), on every transition into FETCH from a non-FETCH state.

Reset
REQ-034 When reset=1 at a rising edge, the block SHALL set state=FETCH and instr_cnt=0, aborting any in-flight instruction.
REQ-035 While reset=1, PCWr, IRWr, RegWrite and MemWrite SHALL be forced to 0, and all other outputs SHALL take their FETCH values.
REQ-036 Reset asserted mid-MEM of sw SHALL suppress MemWrite in that same cycle.

Structure
REQ-037 A shared package SHALL hold:
- opcode/func constants;
- state encodings;
- ALUControl, NPCSel, WDSel and RegDst codes.
REQ-038 Instruction classification SHALL live in one combinational sub-module, mc_decode (op, func -> class one-hots). The FSM and counter stay in multi_cycle_ctrl.

Verification
REQ-039 Reset, then addu (op=0, func=100001): states 0,1,2,4,0; RegWrite=1 only in WB with RegDst=01; instr_cnt=1.
REQ-040 lw then sw: lw takes 5 cycles with WDSel=01 in WB; sw asserts MemWrite=1 for exactly one cycle in MEM; instr_cnt=2.
REQ-041 beq with zero=1, then beq with zero=0: PCWr=1 / NPCSel=01 in EXE only for the first; each takes 3 cycles.
REQ-042 jal: PCWr=1, NPCSel=10, RegWrite=1, RegDst=10, WDSel=10 in DECODE; back to FETCH after 2 cycles.
REQ-043 Undecoded op=111111 and nop: each retires in 2 cycles with no write enables asserted.
REQ-044 Reset asserted during MEM of sw: MemWrite=0 that cycle; next state FETCH; instr_cnt=0.
